// File: rtl/or1k_dpram_pkg.sv
// ---------------------------------------------------------------------------
// or1k_dpram_pkg
// Shared definitions for the true dual-port byte-enable RAM:
//   RW_WRITE_FIRST / RW_READ_FIRST : values of the RW_MODE parameter
//   clr_state_e                    : clear sequencer state encoding
//   be_width()                     : number of byte lanes in a data word
// ---------------------------------------------------------------------------
package or1k_dpram_pkg;

  localparam int RW_WRITE_FIRST = 0;
  localparam int RW_READ_FIRST  = 1;

  typedef enum logic [1:0] {
    CLR_RESET = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_RUN   = 2'd2
  } clr_state_e;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/or1k_dpram_clear_seq.sv
// ---------------------------------------------------------------------------
// or1k_dpram_clear_seq
// Post-reset clear sequencer. Walks every address once, requesting an
// all-zero write for each, then raises ready.
// Ports:
//   i_clk        sole clock
//   i_rst_n      synchronous active-low reset
//   o_ready      high once the array may accept port traffic
//   o_clr_we     write request for the zeroing pass
//   o_clr_addr   address being zeroed
//
// state     | meaning
// CLR_RESET | held in reset; first released edge zeroes address 0
// CLR_CLEAR | zeroing addresses 1 .. last
// CLR_RUN   | clear done, ports live
// ---------------------------------------------------------------------------
module or1k_dpram_clear_seq
  import or1k_dpram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_ready,
  output logic                  o_clr_we,
  output logic [ADDR_WIDTH-1:0] o_clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_e            r_state;
  clr_state_e            w_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  w_clr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= CLR_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_clr) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    case (r_state)
      CLR_RESET: begin
        if (CLEAR_ON_RESET != 0) begin
          // Address 0 is written on the very edge that leaves reset.
          w_clr  = 1'b1;
          w_next = (r_cnt == LAST_ADDR) ? CLR_RUN : CLR_CLEAR;
        end else begin
          w_next = CLR_RUN;
        end
      end
      CLR_CLEAR: begin
        w_clr = 1'b1;
        if (r_cnt == LAST_ADDR) w_next = CLR_RUN;
      end
      CLR_RUN: w_next = CLR_RUN;
      default: w_next = CLR_RESET;
    endcase
  end

  // An edge with reset asserted must not touch the array.
  assign o_clr_we   = w_clr & i_rst_n;
  assign o_clr_addr = r_cnt;
  assign o_ready    = (r_state == CLR_RUN);

endmodule

// File: rtl/or1k_true_dpram_be.sv
// ---------------------------------------------------------------------------
// or1k_true_dpram_be
// Single-clock true dual-port RAM with byte write enables, selectable
// read-during-write behaviour, optional output register, same-address
// collision flag and a zeroing pass after reset.
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   o_ready                        ports accept accesses
//   i_addr_x, i_en_x, i_we_x,      port x (a/b) address, request,
//   i_din_x                        byte enables, write data
//   o_dout_x, o_valid_x            port x read data and valid pulse
//   o_collision                    cross-port same-address conflict
// ---------------------------------------------------------------------------
module or1k_true_dpram_be
  import or1k_dpram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int RW_MODE        = 0,
  parameter int OUTPUT_REG     = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BE_WIDTH      = be_width(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic                  i_en_a,
  input  logic [BE_WIDTH-1:0]   i_we_a,
  input  logic [DATA_WIDTH-1:0] i_din_a,
  output logic [DATA_WIDTH-1:0] o_dout_a,
  output logic                  o_valid_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic                  i_en_b,
  input  logic [BE_WIDTH-1:0]   i_we_b,
  input  logic [DATA_WIDTH-1:0] i_din_b,
  output logic [DATA_WIDTH-1:0] o_dout_b,
  output logic                  o_valid_b,
  output logic                  o_collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  function automatic logic [DATA_WIDTH-1:0] f_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] din,
    input logic [BE_WIDTH-1:0]   we
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int k = 0; k < BE_WIDTH; k++)
      if (we[k]) r[8*k +: 8] = din[8*k +: 8];
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_ready;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;

  or1k_dpram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .o_ready    (w_ready),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  logic                  w_acc_a, w_acc_b;
  logic [BE_WIDTH-1:0]   w_we_a, w_we_b;
  logic                  w_wr_a, w_wr_b;
  logic                  w_same;
  logic [DATA_WIDTH-1:0] w_old_a, w_old_b;
  logic [DATA_WIDTH-1:0] w_new_a, w_new_b;
  logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b;
  logic                  w_coll;
  logic                  w_pa_en;
  logic [ADDR_WIDTH-1:0] w_pa_addr;
  logic [DATA_WIDTH-1:0] w_pa_word;

  assign w_acc_a = i_en_a & w_ready & i_rst_n;
  assign w_acc_b = i_en_b & w_ready & i_rst_n;
  assign w_we_a  = w_acc_a ? i_we_a : '0;
  assign w_we_b  = w_acc_b ? i_we_b : '0;
  assign w_wr_a  = |w_we_a;
  assign w_wr_b  = |w_we_b;
  assign w_same  = (i_addr_a == i_addr_b);
  assign w_old_a = r_mem[i_addr_a];
  assign w_old_b = r_mem[i_addr_b];

  // Both ports compute the full resulting word: B bytes first, A bytes on
  // top, so on a same-address double write both paths store identical data
  // and A wins every overlapping byte.
  assign w_new_a = f_merge(f_merge(w_old_a, i_din_b, w_same ? w_we_b : '0),
                           i_din_a, w_we_a);
  assign w_new_b = f_merge(f_merge(w_old_b, i_din_b, w_we_b),
                           i_din_a, w_same ? w_we_a : '0);

  assign w_coll = w_acc_a & w_acc_b & w_same & (w_wr_a | w_wr_b);

  // The clear sequencer borrows port A's write path until ready.
  assign w_pa_en   = w_ready ? w_wr_a   : w_clr_we;
  assign w_pa_addr = w_ready ? i_addr_a : w_clr_addr;
  assign w_pa_word = w_ready ? w_new_a  : '0;

  always_ff @(posedge i_clk) begin
    if (w_pa_en) r_mem[w_pa_addr] <= w_pa_word;
    if (w_wr_b)  r_mem[i_addr_b]  <= w_new_b;
  end

  // A pure reader always sees the pre-edge word, which is the required
  // result for a cross-port read/write collision.
  assign w_rd_a = (RW_MODE == RW_WRITE_FIRST && w_wr_a) ? w_new_a : w_old_a;
  assign w_rd_b = (RW_MODE == RW_WRITE_FIRST && w_wr_b) ? w_new_b : w_old_b;

  logic [DATA_WIDTH-1:0] r1_dout_a, r1_dout_b;
  logic                  r1_valid_a, r1_valid_b, r1_coll;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r1_dout_a  <= '0;
      r1_dout_b  <= '0;
      r1_valid_a <= 1'b0;
      r1_valid_b <= 1'b0;
      r1_coll    <= 1'b0;
    end else begin
      r1_valid_a <= w_acc_a;
      r1_valid_b <= w_acc_b;
      r1_coll    <= w_coll;
      if (w_acc_a) r1_dout_a <= w_rd_a;
      if (w_acc_b) r1_dout_b <= w_rd_b;
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] r2_dout_a, r2_dout_b;
    logic                  r2_valid_a, r2_valid_b, r2_coll;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r2_dout_a  <= '0;
        r2_dout_b  <= '0;
        r2_valid_a <= 1'b0;
        r2_valid_b <= 1'b0;
        r2_coll    <= 1'b0;
      end else begin
        r2_valid_a <= r1_valid_a;
        r2_valid_b <= r1_valid_b;
        r2_coll    <= r1_coll;
        if (r1_valid_a) r2_dout_a <= r1_dout_a;
        if (r1_valid_b) r2_dout_b <= r1_dout_b;
      end
    end

    assign o_dout_a    = r2_dout_a;
    assign o_dout_b    = r2_dout_b;
    assign o_valid_a   = r2_valid_a;
    assign o_valid_b   = r2_valid_b;
    assign o_collision = r2_coll;
  end else begin : g_nreg
    assign o_dout_a    = r1_dout_a;
    assign o_dout_b    = r1_dout_b;
    assign o_valid_a   = r1_valid_a;
    assign o_valid_b   = r1_valid_b;
    assign o_collision = r1_coll;
  end

  assign o_ready = w_ready;

endmodule

// File: tb/tb_or1k_true_dpram_be.sv
module tb_or1k_true_dpram_be;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          coll;
    int            cyc;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr_a, addr_b;
  logic          en_a, en_b;
  logic [BW-1:0] we_a, we_b;
  logic [DW-1:0] din_a, din_b;

  logic          rdy     [2];
  logic [DW-1:0] dout_a  [2];
  logic [DW-1:0] dout_b  [2];
  logic          valid_a [2];
  logic          valid_b [2];
  logic          coll    [2];

  always #5 clk = ~clk;

  // dut 0: write-first, latency 1; dut 1: read-first, latency 2
  or1k_true_dpram_be #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RW_MODE(0), .OUTPUT_REG(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .o_ready(rdy[0]),
    .i_addr_a(addr_a), .i_en_a(en_a), .i_we_a(we_a), .i_din_a(din_a),
    .o_dout_a(dout_a[0]), .o_valid_a(valid_a[0]),
    .i_addr_b(addr_b), .i_en_b(en_b), .i_we_b(we_b), .i_din_b(din_b),
    .o_dout_b(dout_b[0]), .o_valid_b(valid_b[0]),
    .o_collision(coll[0])
  );

  or1k_true_dpram_be #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RW_MODE(1), .OUTPUT_REG(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .o_ready(rdy[1]),
    .i_addr_a(addr_a), .i_en_a(en_a), .i_we_a(we_a), .i_din_a(din_a),
    .o_dout_a(dout_a[1]), .o_valid_a(valid_a[1]),
    .i_addr_b(addr_b), .i_en_b(en_b), .i_we_b(we_b), .i_din_b(din_b),
    .o_dout_b(dout_b[1]), .o_valid_b(valid_b[1]),
    .o_collision(coll[1])
  );

  int            checks = 0;
  int            errors = 0;
  int            cyc_cnt = 0;
  logic          rst_q;
  logic          mon_en = 1'b0;
  logic [DW-1:0] last [4];
  logic [DW-1:0] m    [DEPTH];
  entry_t        sb   [4][$];   // index = dut*2 + port (0=A, 1=B)

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    rst_q   <= rst_n;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon_port(input int idx, input logic v, input logic [DW-1:0] d,
                          output logic ec);
    entry_t e;
    ec = 1'b0;
    if (v) begin
      if (sb[idx].size() == 0) begin
        chk($sformatf("spurious_valid[%0d]", idx), {31'd0, v}, 32'd0);
      end else begin
        e = sb[idx].pop_front();
        chk($sformatf("dout[%0d]", idx), d, e.data);
        chk($sformatf("latency[%0d]", idx), cyc_cnt, e.cyc);
        ec = e.coll;
        last[idx] = e.data;
      end
    end else begin
      chk($sformatf("hold[%0d]", idx), d, last[idx]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        logic eca, ecb;
        if (!rst_q) begin
          chk($sformatf("rst_valid_a[%0d]", d), {31'd0, valid_a[d]}, 32'd0);
          chk($sformatf("rst_valid_b[%0d]", d), {31'd0, valid_b[d]}, 32'd0);
          chk($sformatf("rst_dout_a[%0d]", d), dout_a[d], 32'd0);
          chk($sformatf("rst_dout_b[%0d]", d), dout_b[d], 32'd0);
          chk($sformatf("rst_coll[%0d]", d), {31'd0, coll[d]}, 32'd0);
          chk($sformatf("rst_ready[%0d]", d), {31'd0, rdy[d]}, 32'd0);
          last[2*d] = '0;
          last[2*d+1] = '0;
        end else begin
          mon_port(2*d,   valid_a[d], dout_a[d], eca);
          mon_port(2*d+1, valid_b[d], dout_b[d], ecb);
          chk($sformatf("collision[%0d]", d), {31'd0, coll[d]}, {31'd0, eca | ecb});
        end
      end
    end
  end

  // One accepted cycle: model the array bytewise (B first, A overrides),
  // queue expected results for both DUTs, then advance one clock.
  task automatic step(input logic ea, input logic [BW-1:0] wa, input logic [AW-1:0] aa,
                      input logic [DW-1:0] da, input logic eb, input logic [BW-1:0] wb,
                      input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic [DW-1:0] oa, ob;
    logic          wra, wrb, c;
    entry_t        e;
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    oa  = m[aa];
    ob  = m[ab];
    wra = ea && (wa != 0);
    wrb = eb && (wb != 0);
    c   = ea && eb && (aa == ab) && (wra || wrb);
    for (int k = 0; k < BW; k++) begin
      if (wrb && wb[k]) m[ab][8*k +: 8] = db[8*k +: 8];
      if (wra && wa[k]) m[aa][8*k +: 8] = da[8*k +: 8];
    end
    if (ea) begin
      e.coll = c;
      e.data = wra ? m[aa] : oa; e.cyc = cyc_cnt + 1; sb[0].push_back(e);
      e.data = oa;               e.cyc = cyc_cnt + 2; sb[2].push_back(e);
    end
    if (eb) begin
      e.coll = c;
      e.data = wrb ? m[ab] : ob; e.cyc = cyc_cnt + 1; sb[1].push_back(e);
      e.data = ob;               e.cyc = cyc_cnt + 2; sb[3].push_back(e);
    end
    @(posedge clk); #1;
    en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Clear pass with ignored writes hammering port A; ready must appear only
  // after the 16th released edge.
  task automatic clear_wait(input string tag);
    en_a = 1'b1; we_a = 4'hF; addr_a = 4'd3; din_a = 32'hFFFF_FFFF;
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk); #1;
      if (i == DEPTH) begin en_a = 1'b0; we_a = '0; end
      for (int d = 0; d < 2; d++)
        chk($sformatf("%s_ready[%0d]_e%0d", tag, d, i), {31'd0, rdy[d]},
            {31'd0, (i == DEPTH)});
    end
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 4'h0, AW'(i), 32'd0, 1'b1, 4'h0, AW'(DEPTH-1-i), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0;
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    for (int i = 0; i < 4; i++) last[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_wait("clr");
    read_all();

    // byte-lane merge, read back from B
    step(1, 4'hF, 4'd3, 32'hAABBCCDD, 0, 4'h0, 4'd0, 32'd0);
    step(1, 4'h5, 4'd3, 32'h11223344, 0, 4'h0, 4'd0, 32'd0);
    step(0, 4'h0, 4'd0, 32'd0,        1, 4'h0, 4'd3, 32'd0);

    // read-during-write on one port
    step(1, 4'hF, 4'd7, 32'h9, 0, 4'h0, 4'd0, 32'd0);
    step(1, 4'hF, 4'd7, 32'h5, 0, 4'h0, 4'd0, 32'd0);

    // write-write collision and readback
    step(1, 4'h1, 4'd2, 32'h000000FF, 1, 4'h3, 4'd2, 32'h12345678);
    step(1, 4'h0, 4'd2, 32'd0,        0, 4'h0, 4'd0, 32'd0);

    // cross collision: A reads while B writes
    step(1, 4'hF, 4'd5, 32'h1, 0, 4'h0, 4'd0, 32'd0);
    step(1, 4'h0, 4'd5, 32'd0, 1, 4'hF, 4'd5, 32'h2);
    step(1, 4'h0, 4'd5, 32'd0, 0, 4'h0, 4'd0, 32'd0);

    // same-address double read is not a collision
    step(1, 4'h0, 4'd3, 32'd0, 1, 4'h0, 4'd3, 32'd0);

    // back-to-back mixed traffic on both ports
    for (int i = 0; i < 40; i++) begin
      logic [BW-1:0] wa, wb;
      wa = ($urandom_range(0, 1) == 1) ? BW'($urandom_range(0, 15)) : 4'h0;
      wb = ($urandom_range(0, 1) == 1) ? BW'($urandom_range(0, 15)) : 4'h0;
      step(1'b1, wa, AW'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), wb, AW'($urandom_range(0, 7)), $urandom);
    end
    idle(3);

    // fill with non-zero data, then reset in the middle of the clear
    for (int i = 0; i < DEPTH; i++)
      step(1, 4'hF, AW'(i), 32'hDEAD0000 | i, 0, 4'h0, 4'd0, 32'd0);
    idle(3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_ready_e%0d", i), {31'd0, rdy[0]}, 32'd0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_wait("reclr");
    read_all();
    idle(4);

    for (int i = 0; i < 4; i++)
      chk($sformatf("sb_empty[%0d]", i), sb[i].size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
